pipe_hazard_ctrl: RTL and testbench

Central pipeline controller that produces the flush, stall and wait controls consumed by the ID/EX pipeline register and the IF/ID stages: `stall`, `t_pnt`, `nt_pt`, `wait_DM1` and `wait_WFI`.
- Detects load-use hazards between ID and EX.
- Resolves branch mispredictions in EX.
- Sequences the data-memory wait handshake, with a timeout.
- Runs a WFI sleep/wake state machine.
- Keeps performance counters for mispredicts and stall cycles.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/hazard_perf_cnt.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
// Encodings here are matched against decoder fields in EX and ID.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } wfi_state_t;

  localparam logic [2:0] DM_READ_NONE = 3'd0;
  localparam logic [4:0] REG_X0       = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Bank of free-running wrapping event counters, one enable per counter.
// Each counter advances by one on any cycle its enable is high.
module hazard_perf_cnt #(
  parameter int NUM_CNT = 2,
  parameter int CNT_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CNT-1:0]              inc,
  output logic [NUM_CNT-1:0][CNT_W-1:0]   cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i]) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline flush/stall/wait controller: load-use, mispredict, DM wait with
// timeout, WFI sleep/wake, plus mispredict and stall-cycle counters.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DM_TIMEOUT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_index,
  input  logic [4:0]       id_rs2_index,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd_index,
  input  logic [2:0]       ex_DM_read,
  input  logic             ex_wb_en,
  input  logic             ex_branch,
  input  logic             ex_pred_taken,
  input  logic             ex_br_taken,
  input  logic             ex_wfi,
  input  logic             irq_pending,
  input  logic             mem_dm_req,
  input  logic             dm_ready,
  output logic             stall,
  output logic             t_pnt,
  output logic             nt_pt,
  output logic             wait_DM1,
  output logic             wait_WFI,
  output logic             dm_timeout,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DMC_W = (DM_TIMEOUT < 1) ? 1 : $clog2(DM_TIMEOUT + 1);
  localparam logic [DMC_W-1:0] DMC_MAX = DMC_W'(DM_TIMEOUT);

  // ---- data-memory wait with forced release ----
  logic [DMC_W-1:0] dmcnt;
  logic             dm_stuck, dm_expire, dm_timeout_q;

  assign dm_stuck  = mem_dm_req & ~dm_ready;
  assign dm_expire = dm_stuck & (dmcnt == DMC_MAX);
  // Combinational outputs are forced low while reset is held so a sleeping
  // or stalled pipe releases immediately, without waiting for a clock.
  assign wait_DM1  = ~rst & dm_stuck & ~dm_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmcnt        <= '0;
      dm_timeout_q <= 1'b0;
    end else begin
      dmcnt        <= wait_DM1 ? dmcnt + 1'b1 : '0;
      dm_timeout_q <= dm_expire;
    end
  end

  assign dm_timeout = dm_timeout_q;

  // ---- WFI sleep/wake ----
  wfi_state_t wfi_state, wfi_state_nxt;
  logic       wfi_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wfi_state <= RUN;
    else     wfi_state <= wfi_state_nxt;
  end

  always_comb begin
    wfi_state_nxt = wfi_state;
    wfi_wait      = 1'b0;
    unique case (wfi_state)
      RUN: begin
        wfi_wait = ex_wfi & ~irq_pending & ~wait_DM1;
        if (wfi_wait) wfi_state_nxt = SLEEP;
      end
      SLEEP: begin
        wfi_wait = 1'b1;
        if (irq_pending) wfi_state_nxt = WAKE;
      end
      // WFI is still sitting in EX here; ignoring it lets it retire.
      WAKE:    wfi_state_nxt = RUN;
      default: wfi_state_nxt = RUN;
    endcase
  end

  assign wait_WFI = ~rst & wfi_wait;

  logic waiting;
  assign waiting = wait_DM1 | wait_WFI;

  // ---- branch resolution; a held branch flushes on the first free cycle ----
  logic br_live;
  assign br_live = ~rst & ex_branch & ~waiting;
  assign t_pnt   = br_live &  ex_pred_taken & ~ex_br_taken;
  assign nt_pt   = br_live & ~ex_pred_taken &  ex_br_taken;

  // ---- load-use; a flush wins because the ID instruction is wrong-path ----
  logic ex_is_ld, rs1_hit, rs2_hit, ld_use;
  assign ex_is_ld = (ex_DM_read != DM_READ_NONE) & ex_wb_en & (ex_rd_index != REG_X0);
  assign rs1_hit  = id_use_rs1 & (id_rs1_index == ex_rd_index);
  assign rs2_hit  = id_use_rs2 & (id_rs2_index == ex_rd_index);
  assign ld_use   = ex_is_ld & (rs1_hit | rs2_hit);
  assign stall    = ~rst & ld_use & ~waiting & ~t_pnt & ~nt_pt;

  // ---- performance counters: [0] mispredicts, [1] lost cycles ----
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {stall | waiting, t_pnt | nt_pt};

  hazard_perf_cnt #(
    .NUM_CNT (2),
    .CNT_W   (CNT_W)
  ) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .cnt (cnt_val)
  );

  assign mispredict_cnt = cnt_val[0];
  assign stall_cnt      = cnt_val[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DM_TIMEOUT=4 and 4-bit counters
// so the forced release and counter wrap are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam int DM_TO = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1_index, id_rs2_index, ex_rd_index;
  logic          id_use_rs1, id_use_rs2;
  logic [2:0]    ex_DM_read;
  logic          ex_wb_en, ex_branch, ex_pred_taken, ex_br_taken;
  logic          ex_wfi, irq_pending, mem_dm_req, dm_ready;
  logic          stall, t_pnt, nt_pt, wait_DM1, wait_WFI, dm_timeout;
  logic [CW-1:0] mispredict_cnt, stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DM_TIMEOUT(DM_TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_index   (id_rs1_index),
    .id_rs2_index   (id_rs2_index),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd_index    (ex_rd_index),
    .ex_DM_read     (ex_DM_read),
    .ex_wb_en       (ex_wb_en),
    .ex_branch      (ex_branch),
    .ex_pred_taken  (ex_pred_taken),
    .ex_br_taken    (ex_br_taken),
    .ex_wfi         (ex_wfi),
    .irq_pending    (irq_pending),
    .mem_dm_req     (mem_dm_req),
    .dm_ready       (dm_ready),
    .stall          (stall),
    .t_pnt          (t_pnt),
    .nt_pt          (nt_pt),
    .wait_DM1       (wait_DM1),
    .wait_WFI       (wait_WFI),
    .dm_timeout     (dm_timeout),
    .mispredict_cnt (mispredict_cnt),
    .stall_cnt      (stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic clr();
    id_rs1_index = '0; id_rs2_index = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd_index = '0; ex_DM_read = '0; ex_wb_en = 0; ex_branch = 0;
    ex_pred_taken = 0; ex_br_taken = 0; ex_wfi = 0; irq_pending = 0;
    mem_dm_req = 0; dm_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [4:0] rd);
    ex_DM_read = 3'b010; ex_wb_en = 1; ex_rd_index = rd;
  endtask

  initial begin
    logic exp_w [7];
    logic exp_t [7];
    exp_w = '{1, 1, 1, 1, 0, 1, 1};
    exp_t = '{0, 0, 0, 0, 0, 1, 0};

    clr();
    rst = 1;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_t_pnt", t_pnt, 0);
    chk("rst_nt_pt", nt_pt, 0);
    chk("rst_wait_dm", wait_DM1, 0);
    chk("rst_wait_wfi", wait_WFI, 0);
    chk("rst_dm_to", dm_timeout, 0);
    chk("rst_misp_cnt", mispredict_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    tick();

    // load-use on rs2
    set_ld(5); id_use_rs2 = 1; id_rs2_index = 5;
    #1 chk("lu_rs2", stall, 1);
    tick();
    chk("lu_cnt1", stall_cnt, 1);
    // destination x0 never hazards
    ex_rd_index = 0; id_rs2_index = 0;
    #1 chk("lu_x0", stall, 0);
    tick();
    chk("lu_cnt_x0", stall_cnt, 1);
    // load-use on rs1
    clr(); set_ld(7); id_use_rs1 = 1; id_rs1_index = 7;
    #1 chk("lu_rs1", stall, 1);
    id_use_rs1 = 0;
    #1 chk("lu_rs1_unused", stall, 0);
    id_use_rs1 = 1; ex_DM_read = 3'd0;
    #1 chk("lu_not_load", stall, 0);
    ex_DM_read = 3'b010;
    tick();
    chk("lu_cnt2", stall_cnt, 2);

    // mispredict overrides load-use
    clr(); set_ld(5); id_use_rs2 = 1; id_rs2_index = 5;
    ex_branch = 1; ex_pred_taken = 0; ex_br_taken = 1;
    #1 chk("mp_nt_pt", nt_pt, 1);
    chk("mp_stall_off", stall, 0);
    chk("mp_t_pnt_off", t_pnt, 0);
    tick();
    chk("mp_cnt1", mispredict_cnt, 1);
    chk("mp_stall_cnt", stall_cnt, 2);
    clr(); ex_branch = 1; ex_pred_taken = 1; ex_br_taken = 0;
    #1 chk("mp_t_pnt", t_pnt, 1);
    chk("mp_nt_pt_off", nt_pt, 0);
    tick();
    chk("mp_cnt2", mispredict_cnt, 2);
    ex_br_taken = 1;
    #1 chk("mp_correct_t", t_pnt, 0);
    chk("mp_correct_n", nt_pt, 0);
    tick();
    chk("mp_cnt_hold", mispredict_cnt, 2);

    // DM wait holds a pending mispredict until dm_ready
    clr(); mem_dm_req = 1; ex_branch = 1; ex_pred_taken = 1;
    set_ld(5); id_use_rs2 = 1; id_rs2_index = 5;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dm_wait", wait_DM1, 1);
      chk("dm_hold_flush", t_pnt, 0);
      chk("dm_hold_stall", stall, 0);
      tick();
    end
    chk("dm_stall_cnt", stall_cnt, 5);
    dm_ready = 1;
    #1 chk("dm_ready_wait", wait_DM1, 0);
    chk("dm_ready_flush", t_pnt, 1);
    chk("dm_ready_stall", stall, 0);
    tick();
    chk("dm_misp_cnt", mispredict_cnt, 3);
    chk("dm_stall_cnt2", stall_cnt, 5);
    clr();
    #1 chk("dm_idle", wait_DM1, 0);
    tick();

    // forced release after DM_TO cycles
    mem_dm_req = 1;
    for (int i = 0; i < 7; i++) begin
      #1 chk($sformatf("to_wait_%0d", i + 1), wait_DM1, exp_w[i]);
      chk($sformatf("to_pulse_%0d", i + 1), dm_timeout, exp_t[i]);
      tick();
    end
    clr();

    rst = 1;
    #1 chk("rst2_misp", mispredict_cnt, 0);
    chk("rst2_stall", stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    tick();

    // WFI sleep, counter wrap, wake
    ex_wfi = 1;
    for (int k = 1; k <= 18; k++) begin
      #1 chk($sformatf("wfi_sleep_%0d", k), wait_WFI, 1);
      tick();
      if (k == 10) chk("wfi_cnt10", stall_cnt, 10);
    end
    chk("wfi_cnt_wrap", stall_cnt, 2);
    irq_pending = 1;
    #1 chk("wfi_irq_cycle", wait_WFI, 1);
    tick();
    chk("wfi_cnt_irq", stall_cnt, 3);
    chk("wfi_wake", wait_WFI, 0);
    tick();
    chk("wfi_run_no_resleep", wait_WFI, 0);
    tick();
    chk("wfi_run_hold", wait_WFI, 0);
    chk("wfi_cnt_final", stall_cnt, 3);
    clr();
    tick();

    // WFI with interrupt already pending never sleeps
    ex_wfi = 1; irq_pending = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wfi_irq_pre", wait_WFI, 0);
      tick();
    end

    // DM wait blocks sleep entry, then WFI sleeps
    irq_pending = 0; mem_dm_req = 1;
    #1 chk("wfi_dm_block", wait_WFI, 0);
    chk("wfi_dm_wait", wait_DM1, 1);
    tick();
    mem_dm_req = 0;
    #1 chk("wfi_after_dm", wait_WFI, 1);
    tick();

    // reset mid-sleep with a timeout pulse outstanding
    mem_dm_req = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("ms_pulse", dm_timeout, 1);
    chk("ms_sleep", wait_WFI, 1);
    #2 rst = 1;
    #1 chk("ms_wfi", wait_WFI, 0);
    chk("ms_dm", wait_DM1, 0);
    chk("ms_pulse_clr", dm_timeout, 0);
    chk("ms_misp_cnt", mispredict_cnt, 0);
    chk("ms_stall_cnt", stall_cnt, 0);
    clr();
    @(negedge clk);
    rst = 0;
    tick();
    chk("ms_run", wait_WFI, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
